imem_fetch_sequencer: RTL and testbench

- Sequences the byte-wide, big-endian instruction memory.
- Issues one byte read per cycle and assembles 32-bit instruction words.
- Buffers assembled words in a small prefetch FIFO and presents them to the core's decode stage over a valid/ready handshake.
- Handles PC redirects (branch/jump) by flushing the FIFO and any in-flight fetch, and flags fetches beyond memory bounds.

---
 rtl/imem_fetch_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_imem_fetch_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_sequencer.sv
// Byte-serial big-endian instruction fetch into a prefetch FIFO; first word valid 6 cycles after reset/redirect, one word per 4 cycles.
// Word fetch starts only with a FIFO slot reserved, so decode backpressure stalls fetch in WAIT; FETCH_PERF_EN adds perf counters.
module imem_fetch_sequencer #(
   parameter int          MEMORY_SIZE = 16,
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [31:0] RESET_PC    = 32'd0
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_rd_en,
   output logic [31:0] mem_addr,
   input  logic [7:0]  mem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   output logic        inst_fault
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_words,
   output logic [31:0] perf_stall
`endif
);

   localparam int          PW      = $clog2(FIFO_DEPTH);
   localparam int          CW      = PW + 1;
   localparam logic [31:0] LAST_PC = 32'(MEMORY_SIZE - 4);

   typedef enum logic [1:0] {ISSUE, WAIT, HALT} state_t;

   state_t        state;
   logic [1:0]    cnt;
   logic [31:0]   fetch_pc;
   logic [31:0]   word_pc;
   logic          busy;
   logic          ret_vld;
   logic [1:0]    ret_idx;
   logic [23:0]   asm_q;

   logic [31:0]   fifo_data  [FIFO_DEPTH];
   logic [31:0]   fifo_pc    [FIFO_DEPTH];
   logic          fifo_fault [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic          space;
   logic          oob;
   logic          word_start;
   logic          rd_go;
   logic          fault_go;
   logic          ret_push;
   logic          push;
   logic          pop;
   logic [31:0]   push_data;
   logic [31:0]   push_pc;
   logic          push_fault;
   logic [CW-1:0] kept;
   logic [CW-1:0] nxt_count;
   logic [PW-1:0] nxt_rd;
   logic          head_from_push;

   // busy reserves a FIFO slot for the word being fetched until its last byte is pushed
   assign space      = (count + CW'(busy)) < CW'(FIFO_DEPTH);
   assign oob        = fetch_pc > LAST_PC;
   assign word_start = (state == ISSUE) && (cnt == 2'd0);
   assign rd_go      = !rst && (state == ISSUE) && ((cnt != 2'd0) || (space && !oob));
   // a fault entry waits for the previous word's push so only one push happens per cycle
   assign fault_go   = word_start && space && oob && !busy;
   assign ret_push   = ret_vld && (ret_idx == 2'd3);
   assign push       = ret_push || fault_go;
   assign push_data  = fault_go ? 32'd0 : {asm_q, mem_rdata};
   assign push_pc    = fault_go ? fetch_pc : word_pc;
   assign push_fault = fault_go;
   assign pop        = inst_valid && inst_ready;

   assign mem_rd_en  = rd_go;
   assign mem_addr   = rd_go ? (fetch_pc + {30'd0, cnt}) : 32'd0;

   assign kept           = count - CW'(pop);
   assign nxt_count      = kept + CW'(push);
   assign nxt_rd         = rd_ptr + PW'(pop);
   assign head_from_push = push && (kept == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ISSUE;
         cnt      <= 2'd0;
         fetch_pc <= RESET_PC;
         word_pc  <= 32'd0;
         busy     <= 1'b0;
         ret_vld  <= 1'b0;
         ret_idx  <= 2'd0;
         asm_q    <= 24'd0;
      end else if (redirect_valid) begin
         state    <= ISSUE;
         cnt      <= 2'd0;
         fetch_pc <= redirect_pc & ~32'd3;
         busy     <= 1'b0;
         ret_vld  <= 1'b0;
      end else begin
         ret_vld <= rd_go;
         ret_idx <= cnt;
         if (ret_vld) begin
            asm_q <= {asm_q[15:0], mem_rdata};
         end
         if (word_start && rd_go) begin
            busy <= 1'b1;
         end else if (ret_push) begin
            busy <= 1'b0;
         end
         case (state)
            ISSUE: begin
               if (cnt != 2'd0) begin
                  cnt <= cnt + 2'd1;
                  if (cnt == 2'd3) begin
                     fetch_pc <= fetch_pc + 32'd4;
                  end
               end else if (!space) begin
                  state <= WAIT;
               end else if (oob) begin
                  if (!busy) begin
                     state <= HALT;
                  end
               end else begin
                  cnt     <= 2'd1;
                  word_pc <= fetch_pc;
               end
            end
            WAIT: begin
               if (space) begin
                  state <= ISSUE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr]  <= push_data;
         fifo_pc[wr_ptr]    <= push_pc;
         fifo_fault[wr_ptr] <= push_fault;
      end
   end

   // head is a register copy so it holds its last value once the FIFO drains
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         inst_valid <= 1'b0;
         inst_data  <= 32'd0;
         inst_pc    <= 32'd0;
         inst_fault <= 1'b0;
      end else if (redirect_valid) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         inst_valid <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         rd_ptr     <= nxt_rd;
         count      <= nxt_count;
         inst_valid <= (nxt_count != '0);
         if (head_from_push) begin
            inst_data  <= push_data;
            inst_pc    <= push_pc;
            inst_fault <= push_fault;
         end else if (nxt_count != '0) begin
            inst_data  <= fifo_data[nxt_rd];
            inst_pc    <= fifo_pc[nxt_rd];
            inst_fault <= fifo_fault[nxt_rd];
         end
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_words <= 32'd0;
         perf_stall <= 32'd0;
      end else begin
         if (push && !redirect_valid) begin
            perf_words <= perf_words + 32'd1;
         end
         if (state == WAIT) begin
            perf_stall <= perf_stall + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Directed scenarios plus a random ready/redirect/reset phase against a word-stream model of the fetch sequencer.
module tb_imem_fetch_sequencer;

   localparam logic [31:0] RESET_PC = 32'd0;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_rd_en;
   logic [31:0] mem_addr;
   logic [7:0]  mem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_fault;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_words;
   logic [31:0] perf_stall;
`endif

   always #5 clk = ~clk;

   imem_fetch_sequencer #(
      .MEMORY_SIZE(16),
      .FIFO_DEPTH (4),
      .RESET_PC   (RESET_PC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .mem_rd_en     (mem_rd_en),
      .mem_addr      (mem_addr),
      .mem_rdata     (mem_rdata),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .inst_valid    (inst_valid),
      .inst_ready    (inst_ready),
      .inst_data     (inst_data),
      .inst_pc       (inst_pc),
      .inst_fault    (inst_fault)
`ifdef FETCH_PERF_EN
      ,
      .perf_words    (perf_words),
      .perf_stall    (perf_stall)
`endif
   );

   logic [7:0] tbmem [16];

   always @(posedge clk) begin
      mem_rdata <= (mem_rd_en && mem_addr < 32'd16) ? tbmem[mem_addr[3:0]] : 8'($urandom);
   end

   typedef struct packed {
      logic [31:0] d;
      logic [31:0] pc;
      logic        f;
   } ent_t;

   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   int   rd_cnt = 0;
   ent_t exp_q[$];
   int   pop_cyc[$];
   logic hold_prev = 1'b0;
   ent_t held;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] word_at(input logic [31:0] p);
      logic [3:0] a;
      a = p[3:0];
      return {tbmem[a], tbmem[a + 4'd1], tbmem[a + 4'd2], tbmem[a + 4'd3]};
   endfunction

   function automatic int pop_at(input int i);
      return (i < pop_cyc.size()) ? pop_cyc[i] : -1;
   endfunction

   // expected stream from a start pc: every in-range word in order, then one fault entry
   task automatic build(input logic [31:0] pc);
      logic [31:0] p;
      ent_t        e;
      exp_q.delete();
      p = pc & ~32'd3;
      while (p <= 32'd12) begin
         e.d = word_at(p); e.pc = p; e.f = 1'b0;
         exp_q.push_back(e);
         p = p + 32'd4;
      end
      e.d = 32'd0; e.pc = p; e.f = 1'b1;
      exp_q.push_back(e);
   endtask

   task automatic run_cycle();
      ent_t front;
      #1;
      if (mem_rd_en) begin
         rd_cnt++;
         chk("addr_in_range", {63'd0, mem_addr < 32'd16}, 64'd1);
      end
      if (hold_prev) begin
         chk("hold_valid", inst_valid, 1);
         chk("hold_data", inst_data, held.d);
         chk("hold_pc", inst_pc, held.pc);
         chk("hold_fault", inst_fault, held.f);
      end
      hold_prev = 1'b0;
      if (rst) begin
         build(RESET_PC);
         rd_cnt = 0;
      end else if (redirect_valid) begin
         build(redirect_pc);
         rd_cnt = 0;
      end else begin
         if (inst_valid && inst_ready) begin
            chk("stream_len", inst_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
               front = exp_q.pop_front();
               chk("sb_data", inst_data, front.d);
               chk("sb_pc", inst_pc, front.pc);
               chk("sb_fault", inst_fault, front.f);
            end
            pop_cyc.push_back(cyc);
         end
         if (inst_valid === 1'b1 && !inst_ready) begin
            hold_prev = 1'b1;
            held.d = inst_data; held.pc = inst_pc; held.f = inst_fault;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // cycle 0 is the last reset cycle; first non-reset cycle is 1
   task automatic do_reset();
      rst = 1'b1;
      run_cycle();
      chk("rst_rd_en", mem_rd_en, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_valid", inst_valid, 0);
      chk("rst_data", inst_data, 0);
      chk("rst_pc", inst_pc, 0);
      chk("rst_fault", inst_fault, 0);
      cyc = 0;
      run_cycle();
      rst = 1'b0;
   endtask

   initial begin
      int t;
      int s;
      rst = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'd0;
      inst_ready = 1'b0;
      for (int i = 0; i < 16; i++) tbmem[i] = 8'(i);

      // full sweep with a free-running consumer
      inst_ready = 1'b1;
      do_reset();
      pop_cyc.delete();
      repeat (30) run_cycle();
      chk("s1_first_valid", pop_at(0), 6);
      chk("s1_word1", pop_at(1), 10);
      chk("s1_word2", pop_at(2), 14);
      chk("s1_word3", pop_at(3), 18);
      chk("s1_pops", pop_cyc.size(), 5);
      chk("s1_drained", exp_q.size(), 0);
      chk("s1_reads", rd_cnt, 16);
      chk("s1_halt_rd", mem_rd_en, 0);
`ifdef FETCH_PERF_EN
      chk("perf_words", perf_words, 5);
`endif

      // redirect out of HALT
      pop_cyc.delete();
      t = cyc;
      redirect_valid = 1'b1;
      redirect_pc = 32'd4;
      run_cycle();
      redirect_valid = 1'b0;
      repeat (30) run_cycle();
      chk("s5_first_valid", pop_at(0), t + 6);
      chk("s5_drained", exp_q.size(), 0);

      // stalled consumer: FIFO fills, fetch waits
      inst_ready = 1'b0;
      do_reset();
      repeat (19) run_cycle();
      chk("s2_reads", rd_cnt, 16);
      chk("s2_wait_rd", mem_rd_en, 0);
      chk("s2_head_valid", inst_valid, 1);
      chk("s2_head_data", inst_data, 32'h00010203);
`ifdef FETCH_PERF_EN
      s = int'(perf_stall);
      repeat (5) run_cycle();
      chk("s2_perf_stall", perf_stall - 32'(s), 5);
      repeat (5) run_cycle();
`else
      s = 0;
      repeat (10) run_cycle();
`endif
      inst_ready = 1'b1;
      run_cycle();
      inst_ready = 1'b0;
      repeat (10) run_cycle();
      chk("s2_one_more_no_reads", rd_cnt, 16 + s * 0);
      chk("s2_new_head", inst_pc, 4);
      inst_ready = 1'b1;
      pop_cyc.delete();
      repeat (10) run_cycle();
      chk("s2_drain_pops", pop_cyc.size(), 4);
      chk("s2_drained", exp_q.size(), 0);

      // redirect to 0x0A while the word at 8 is at its third byte
      inst_ready = 1'b0;
      do_reset();
      repeat (10) run_cycle();
      chk("s3_cnt2_rd", mem_rd_en, 1);
      chk("s3_cnt2_addr", mem_addr, 10);
      chk("s3_pre_valid", inst_valid, 1);
      pop_cyc.delete();
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000000A;
      run_cycle();
      redirect_valid = 1'b0;
      chk("s3_flushed", inst_valid, 0);
      inst_ready = 1'b1;
      repeat (12) run_cycle();
      chk("s3_first_valid", pop_at(0), 17);
      repeat (12) run_cycle();
      chk("s3_drained", exp_q.size(), 0);

      // redirect and pop together with three entries queued
      inst_ready = 1'b0;
      do_reset();
      repeat (13) run_cycle();
      chk("s4_head_pc", inst_pc, 0);
      pop_cyc.delete();
      inst_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'd4;
      run_cycle();
      redirect_valid = 1'b0;
      chk("s4_flushed", inst_valid, 0);
      repeat (10) run_cycle();
      chk("s4_first_valid", pop_at(0), 20);
      repeat (15) run_cycle();
      chk("s4_drained", exp_q.size(), 0);

      // reset in the middle of a word
      inst_ready = 1'b1;
      do_reset();
      repeat (5) run_cycle();
      chk("s6_cnt1_addr", mem_addr, 5);
      chk("s6_head_data", inst_data, 32'h00010203);
      pop_cyc.delete();
      do_reset();
      repeat (10) run_cycle();
      chk("s6_first_valid", pop_at(0), 6);

      // random memory, consumer, redirects and resets
      for (int i = 0; i < 16; i++) tbmem[i] = 8'($urandom);
      inst_ready = 1'b1;
      do_reset();
      repeat (3000) begin
         inst_ready = ($urandom % 4) != 0;
         redirect_valid = ($urandom % 40) == 0;
         redirect_pc = $urandom_range(0, 23);
         rst = ($urandom % 500) == 0;
         run_cycle();
      end
      rst = 1'b0;
      redirect_valid = 1'b0;
      inst_ready = 1'b1;
      repeat (40) run_cycle();
      chk("rand_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
